wishbone_ram_router: RTL and testbench

WISHBONE_RAM_ROUTER -- requirements
Module: wishbone_ram_router

---
 rtl/wishbone_ram_router.sv | 210 +++++++++++++++++++++
 tb/tb_wishbone_ram_router.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wishbone_ram_router.sv
// Wishbone classic router: one upstream slave port fanned out to NPORTS
// downstream RAM/ROM windows. One transaction in flight at a time, with
// address decode, read-only protection, an ack timeout and a fault log.
module wishbone_ram_router #(
    parameter int                   NPORTS     = 11,
    parameter logic [31:0]          BASE_ADDR  = 32'h3000_0000,
    parameter logic [NPORTS*32-1:0] PORT_MASKS = {NPORTS{32'hffff_f000}},
    parameter logic [15:0]          RO_PORTS   = 16'h0400,
    parameter int                   TIMEOUT    = 255,
    parameter logic [31:0]          ERR_DATA   = 32'hDEAD_BEEF
) (
    input  logic                   wb_clk_i,
    input  logic                   wb_rst_i,
    input  logic                   wbs_ufp_cyc_i,
    input  logic                   wbs_ufp_stb_i,
    input  logic                   wbs_ufp_we_i,
    input  logic [3:0]             wbs_ufp_sel_i,
    input  logic [31:0]            wbs_ufp_adr_i,
    input  logic [31:0]            wbs_ufp_dat_i,
    output logic                   wbs_ufp_ack_o,
    output logic                   wbs_ufp_err_o,
    output logic [31:0]            wbs_ufp_dat_o,
    output logic [NPORTS-1:0]      wbs_dfp_cyc_o,
    output logic [NPORTS-1:0]      wbs_dfp_stb_o,
    output logic [NPORTS-1:0]      wbs_dfp_we_o,
    output logic [4*NPORTS-1:0]    wbs_dfp_sel_o,
    output logic [32*NPORTS-1:0]   wbs_dfp_adr_o,
    output logic [32*NPORTS-1:0]   wbs_dfp_dat_o,
    input  logic [32*NPORTS-1:0]   wbs_dfp_dat_i,
    input  logic [NPORTS-1:0]      wbs_dfp_ack_i,
    output logic [31:0]            fault_adr_o,
    output logic [7:0]             fault_cnt_o
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    state_t       state_q, state_d;
    logic [3:0]   port_q, port_d;
    logic [31:0]  adr_q, adr_d;
    logic [31:0]  wdat_q, wdat_d;
    logic [3:0]   sel_q, sel_d;
    logic         we_q, we_d;
    logic [15:0]  cnt_q, cnt_d;
    logic         ack_q, ack_d;
    logic         err_q, err_d;
    logic [31:0]  rdat_q, rdat_d;
    logic [31:0]  fault_adr_q, fault_adr_d;
    logic [7:0]   fault_cnt_q, fault_cnt_d;

    logic [NPORTS-1:0] hit;
    logic [NPORTS-1:0] sel_onehot;
    logic [NPORTS-1:0] drive;
    logic [31:0]       dat_masked [NPORTS];
    logic [3:0]        hit_port;
    logic              hit_any;
    logic              ro_hit;
    logic              ack_sel;
    logic [31:0]       dat_sel;
    logic [7:0]        fault_cnt_inc;

    // Per-port decode and downstream drive; only the latched port is driven while ACTIVE.
    for (genvar gi = 0; gi < NPORTS; gi++) begin : g_port
        localparam logic [31:0] PBASE = BASE_ADDR | (32'(gi) << 16);
        localparam logic [31:0] PMASK = PORT_MASKS[gi*32 +: 32];

        assign hit[gi] = (wbs_ufp_adr_i[31:20] == BASE_ADDR[31:20])
                      && (wbs_ufp_adr_i[19:16] == 4'(gi))
                      && ((wbs_ufp_adr_i & PMASK) == (PBASE & PMASK));

        assign sel_onehot[gi] = (port_q == 4'(gi));
        assign drive[gi]      = (state_q == ST_ACTIVE) && sel_onehot[gi];

        assign wbs_dfp_cyc_o[gi]          = drive[gi];
        assign wbs_dfp_stb_o[gi]          = drive[gi];
        assign wbs_dfp_we_o[gi]           = drive[gi] & we_q;
        assign wbs_dfp_sel_o[gi*4 +: 4]   = drive[gi] ? sel_q  : 4'h0;
        assign wbs_dfp_adr_o[gi*32 +: 32] = drive[gi] ? adr_q  : 32'h0;
        assign wbs_dfp_dat_o[gi*32 +: 32] = drive[gi] ? wdat_q : 32'h0;

        assign dat_masked[gi] = wbs_dfp_dat_i[gi*32 +: 32] & {32{sel_onehot[gi]}};
    end

    // Encode the (at most one) hitting port and mux the selected port's read data.
    always_comb begin
        hit_port = 4'h0;
        dat_sel  = 32'h0;
        for (int i = 0; i < NPORTS; i++) begin
            if (hit[i]) begin
                hit_port = 4'(i);
            end
            dat_sel = dat_sel | dat_masked[i];
        end
    end

    assign hit_any       = |hit;
    assign ro_hit        = RO_PORTS[hit_port];
    assign ack_sel       = |(wbs_dfp_ack_i & sel_onehot);
    assign fault_cnt_inc = (fault_cnt_q == 8'hff) ? 8'hff : fault_cnt_q + 8'd1;

    // Next-state logic: decode in IDLE, wait for ack/timeout/abort in ACTIVE, one-cycle RESP.
    always_comb begin
        state_d     = state_q;
        port_d      = port_q;
        adr_d       = adr_q;
        wdat_d      = wdat_q;
        sel_d       = sel_q;
        we_d        = we_q;
        cnt_d       = cnt_q;
        ack_d       = 1'b0;
        err_d       = 1'b0;
        rdat_d      = 32'h0;
        fault_adr_d = fault_adr_q;
        fault_cnt_d = fault_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (wbs_ufp_cyc_i && wbs_ufp_stb_i) begin
                    adr_d  = wbs_ufp_adr_i;
                    wdat_d = wbs_ufp_dat_i;
                    sel_d  = wbs_ufp_sel_i;
                    we_d   = wbs_ufp_we_i;
                    if (hit_any && !(wbs_ufp_we_i && ro_hit)) begin
                        port_d  = hit_port;
                        cnt_d   = 16'h0;
                        state_d = ST_ACTIVE;
                    end else begin
                        // Unmapped address or write to ROM: answer immediately with an error.
                        state_d     = ST_RESP;
                        ack_d       = 1'b1;
                        err_d       = 1'b1;
                        rdat_d      = wbs_ufp_we_i ? 32'h0 : ERR_DATA;
                        fault_adr_d = wbs_ufp_adr_i;
                        fault_cnt_d = fault_cnt_inc;
                    end
                end
            end

            ST_ACTIVE: begin
                if (!wbs_ufp_cyc_i) begin
                    // Master gave up: drop the slave silently, nothing is logged.
                    state_d = ST_IDLE;
                end else if (ack_sel) begin
                    state_d = ST_RESP;
                    ack_d   = 1'b1;
                    rdat_d  = we_q ? 32'h0 : dat_sel;
                end else if (cnt_q == 16'(TIMEOUT - 1)) begin
                    // Strobe has now been high for TIMEOUT cycles with no ack.
                    state_d     = ST_RESP;
                    ack_d       = 1'b1;
                    err_d       = 1'b1;
                    rdat_d      = we_q ? 32'h0 : ERR_DATA;
                    fault_adr_d = adr_q;
                    fault_cnt_d = fault_cnt_inc;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end

            ST_RESP: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and registered response; reset clears everything including the fault log.
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_i) begin
            state_q     <= ST_IDLE;
            port_q      <= 4'h0;
            adr_q       <= 32'h0;
            wdat_q      <= 32'h0;
            sel_q       <= 4'h0;
            we_q        <= 1'b0;
            cnt_q       <= 16'h0;
            ack_q       <= 1'b0;
            err_q       <= 1'b0;
            rdat_q      <= 32'h0;
            fault_adr_q <= 32'h0;
            fault_cnt_q <= 8'h0;
        end else begin
            state_q     <= state_d;
            port_q      <= port_d;
            adr_q       <= adr_d;
            wdat_q      <= wdat_d;
            sel_q       <= sel_d;
            we_q        <= we_d;
            cnt_q       <= cnt_d;
            ack_q       <= ack_d;
            err_q       <= err_d;
            rdat_q      <= rdat_d;
            fault_adr_q <= fault_adr_d;
            fault_cnt_q <= fault_cnt_d;
        end
    end

    assign wbs_ufp_ack_o = ack_q;
    assign wbs_ufp_err_o = err_q;
    assign wbs_ufp_dat_o = rdat_q;
    assign fault_adr_o   = fault_adr_q;
    assign fault_cnt_o   = fault_cnt_q;

endmodule

// File: tb/tb_wishbone_ram_router.sv
// Randomized bench for wishbone_ram_router against a transaction-level model:
// each request's decode, response timing, data and fault log are derived
// from the address map and per-transaction slave behaviour.
module tb_wishbone_ram_router;

    localparam int          NP  = 11;
    localparam int          TO  = 8;
    localparam logic [31:0] ERR = 32'hDEAD_BEEF;
    localparam logic [NP*32-1:0] MASKS = {{10{32'hffff_f000}}, 32'hffff_fc00};

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 cyc, stb, we;
    logic [3:0]           sel;
    logic [31:0]          adr, wdat;
    logic                 wbs_ufp_ack_o, wbs_ufp_err_o;
    logic [31:0]          wbs_ufp_dat_o;
    logic [NP-1:0]        wbs_dfp_cyc_o, wbs_dfp_stb_o, wbs_dfp_we_o;
    logic [4*NP-1:0]      wbs_dfp_sel_o;
    logic [32*NP-1:0]     wbs_dfp_adr_o, wbs_dfp_dat_o;
    logic [32*NP-1:0]     dat_in;
    logic [NP-1:0]        ack_in;
    logic [31:0]          fault_adr_o;
    logic [7:0]           fault_cnt_o;

    wishbone_ram_router #(
        .NPORTS(NP), .BASE_ADDR(32'h3000_0000), .PORT_MASKS(MASKS),
        .RO_PORTS(16'h0400), .TIMEOUT(TO), .ERR_DATA(ERR)
    ) dut (
        .wb_clk_i(clk), .wb_rst_i(rst_n),
        .wbs_ufp_cyc_i(cyc), .wbs_ufp_stb_i(stb), .wbs_ufp_we_i(we),
        .wbs_ufp_sel_i(sel), .wbs_ufp_adr_i(adr), .wbs_ufp_dat_i(wdat),
        .wbs_ufp_ack_o(wbs_ufp_ack_o), .wbs_ufp_err_o(wbs_ufp_err_o),
        .wbs_ufp_dat_o(wbs_ufp_dat_o),
        .wbs_dfp_cyc_o(wbs_dfp_cyc_o), .wbs_dfp_stb_o(wbs_dfp_stb_o),
        .wbs_dfp_we_o(wbs_dfp_we_o), .wbs_dfp_sel_o(wbs_dfp_sel_o),
        .wbs_dfp_adr_o(wbs_dfp_adr_o), .wbs_dfp_dat_o(wbs_dfp_dat_o),
        .wbs_dfp_dat_i(dat_in), .wbs_dfp_ack_i(ack_in),
        .fault_adr_o(fault_adr_o), .fault_cnt_o(fault_cnt_o)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int stb_acc  = 0;
    logic chk_en = 1'b0;
    logic [15:0] ro_ports = 16'h0400;

    // Model expectations for the current cycle.
    int          e_port;
    logic [31:0] e_adr, e_wdat, e_rdat;
    logic [3:0]  e_sel;
    logic        e_we, e_ack, e_err;
    int          m_fault_cnt;
    logic [31:0] m_fault_adr;

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    // Address map rule: matching base, valid port number, in-window under that port's mask.
    function automatic logic is_hit(input logic [31:0] a);
        int p;
        logic [31:0] m, b;
        p = int'(a[19:16]);
        if (a[31:20] != 12'h300) return 1'b0;
        if (p >= NP) return 1'b0;
        m = (p == 0) ? 32'hffff_fc00 : 32'hffff_f000;
        b = 32'h3000_0000 | (32'(p) << 16);
        return (a & m) == (b & m);
    endfunction

    // Per-cycle compare of every DUT output against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            logic [NP-1:0]    ev;
            logic [NP-1:0]    ew;
            logic [4*NP-1:0]  es;
            logic [32*NP-1:0] ea, ed;
            ev = '0; ew = '0; es = '0; ea = '0; ed = '0;
            if (e_port >= 0) begin
                ev[e_port]         = 1'b1;
                ew[e_port]         = e_we;
                es[e_port*4 +: 4]  = e_sel;
                ea[e_port*32 +: 32] = e_adr;
                ed[e_port*32 +: 32] = e_wdat;
            end
            chk("dfp_cyc", wbs_dfp_cyc_o, ev);
            chk("dfp_stb", wbs_dfp_stb_o, ev);
            chk("dfp_we", wbs_dfp_we_o, ew);
            chk("dfp_sel", wbs_dfp_sel_o, es);
            chk("dfp_adr", wbs_dfp_adr_o, ea);
            chk("dfp_dat", wbs_dfp_dat_o, ed);
            chk("ufp_ack", wbs_ufp_ack_o, e_ack);
            chk("ufp_err", wbs_ufp_err_o, e_err);
            chk("ufp_dat", wbs_ufp_dat_o, e_rdat);
            chk("fault_adr", fault_adr_o, m_fault_adr);
            chk("fault_cnt", fault_cnt_o, m_fault_cnt[7:0]);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        stb_acc += $countones(wbs_dfp_stb_o);
    endtask

    task automatic noise(input int p);
        ack_in = NP'($urandom);
        if (p >= 0) ack_in[p] = 1'b0;
        for (int i = 0; i < NP; i++) dat_in[i*32 +: 32] = $urandom;
    endtask

    task automatic set_idle();
        e_port = -1; e_ack = 1'b0; e_err = 1'b0; e_rdat = 32'h0;
    endtask

    task automatic bump_fault(input logic [31:0] a);
        m_fault_cnt = (m_fault_cnt >= 255) ? 255 : m_fault_cnt + 1;
        m_fault_adr = a;
    endtask

    // mode 0: slave acks in the (d+1)th strobe cycle; 1: slave never acks; 2: master drops cyc in the (d+1)th strobe cycle.
    task automatic do_txn(input logic [31:0] a, input logic w, input logic [3:0] s,
                          input logic [31:0] wd, input int mode, input int d,
                          input logic [31:0] rd, output logic r_ack, output logic r_err,
                          output logic [31:0] r_dat, output int n_stb);
        int p;
        int limit;
        p = int'(a[19:16]);
        stb_acc = 0; r_ack = 1'b0; r_err = 1'b0; r_dat = 32'h0;
        cyc = 1'b1; stb = 1'b1; we = w; sel = s; adr = a; wdat = wd;
        noise(-1); set_idle();
        if (!is_hit(a) || (w && ro_ports[p])) begin
            step(); noise(-1);
            bump_fault(a);
            e_ack = 1'b1; e_err = 1'b1; e_rdat = w ? 32'h0 : ERR;
            r_ack = wbs_ufp_ack_o; r_err = wbs_ufp_err_o; r_dat = wbs_ufp_dat_o;
            step(); cyc = 1'b0; stb = 1'b0; noise(-1); set_idle();
        end else begin
            limit = (mode == 1) ? TO : d + 1;
            for (int c = 1; c <= limit; c++) begin
                step(); noise(p);
                e_port = p; e_adr = a; e_wdat = wd; e_sel = s; e_we = w;
                e_ack = 1'b0; e_err = 1'b0; e_rdat = 32'h0;
                if (mode == 0 && c == limit) begin
                    ack_in[p] = 1'b1;
                    dat_in[p*32 +: 32] = rd;
                end
                if (mode == 2 && c == limit) begin
                    cyc = 1'b0; stb = 1'b0;
                end
            end
            step(); noise(-1); set_idle();
            if (mode == 2) begin
                ack_in[p] = 1'b1;
                r_ack = wbs_ufp_ack_o;
                step(); noise(-1);
                r_ack = r_ack | wbs_ufp_ack_o;
            end else begin
                e_ack = 1'b1;
                e_err = (mode == 1);
                e_rdat = w ? 32'h0 : ((mode == 1) ? ERR : rd);
                if (mode == 1) bump_fault(a);
                r_ack = wbs_ufp_ack_o; r_err = wbs_ufp_err_o; r_dat = wbs_ufp_dat_o;
                step(); cyc = 1'b0; stb = 1'b0; noise(-1); set_idle();
            end
        end
        n_stb = stb_acc;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic        ra, re;
        logic [31:0] rdd, a;
        int          ns, p, mode;

        rst_n = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0;
        adr = 32'h0; wdat = 32'h0; ack_in = '0; dat_in = '0;
        set_idle(); m_fault_cnt = 0; m_fault_adr = 32'h0;
        e_adr = 0; e_wdat = 0; e_sel = 0; e_we = 0;
        repeat (3) step();
        chk_en = 1'b1;
        step(); rst_n = 1'b1;
        step();
        chk("reset_ack", wbs_ufp_ack_o, 1'b0);
        chk("reset_fault_cnt", fault_cnt_o, 8'd0);
        chk("reset_stb", wbs_dfp_stb_o, '0);

        // Read port 3, slave acks two cycles after strobe rises.
        do_txn(32'h3003_0010, 1'b0, 4'hf, 32'h0, 0, 2, 32'hCAFE_0033, ra, re, rdd, ns);
        $display("txn rd3 ack=%0d err=%0d dat=%h stb=%0d", ra, re, rdd, ns);
        chk("p3_ack", ra, 1'b1);
        chk("p3_err", re, 1'b0);
        chk("p3_dat", rdd, 32'hCAFE_0033);
        chk("p3_stb_cycles", ns, 3);

        // Write to read-only port 10.
        do_txn(32'h300a_0000, 1'b1, 4'hf, 32'h1111_2222, 0, 0, 32'h0, ra, re, rdd, ns);
        $display("txn wr10 ack=%0d err=%0d stb=%0d", ra, re, ns);
        chk("ro_ack", ra, 1'b1);
        chk("ro_err", re, 1'b1);
        chk("ro_stb_cycles", ns, 0);
        chk("ro_fault_cnt", fault_cnt_o, 8'd1);
        chk("ro_fault_adr", fault_adr_o, 32'h300a_0000);

        // Read outside port 0's narrower window.
        do_txn(32'h3000_0400, 1'b0, 4'hf, 32'h0, 0, 0, 32'h0, ra, re, rdd, ns);
        $display("txn rd0oob ack=%0d err=%0d dat=%h", ra, re, rdd);
        chk("oob_err", re, 1'b1);
        chk("oob_dat", rdd, 32'hDEAD_BEEF);

        // Port 5 never acks.
        do_txn(32'h3005_0100, 1'b0, 4'hf, 32'h0, 1, 0, 32'h0, ra, re, rdd, ns);
        $display("txn to5 ack=%0d err=%0d stb=%0d cnt=%0d", ra, re, ns, fault_cnt_o);
        chk("to_stb_cycles", ns, 8);
        chk("to_err", re, 1'b1);
        chk("to_fault_cnt", fault_cnt_o, 8'd3);

        // Master aborts, slave acks late; then a normal write completes.
        do_txn(32'h3002_0040, 1'b0, 4'hf, 32'h0, 2, 1, 32'h0, ra, re, rdd, ns);
        $display("txn abort ack=%0d stb=%0d", ra, ns);
        chk("abort_no_ack", ra, 1'b0);
        do_txn(32'h3002_0044, 1'b1, 4'h3, 32'h5555_aaaa, 0, 1, 32'h0, ra, re, rdd, ns);
        $display("txn after_abort ack=%0d err=%0d dat=%h", ra, re, rdd);
        chk("post_abort_ack", ra, 1'b1);
        chk("post_abort_err", re, 1'b0);
        chk("post_abort_dat", rdd, 32'h0);

        // Randomized traffic.
        for (int t = 0; t < 200; t++) begin
            p = $urandom_range(0, 12);
            a = (($urandom_range(0, 7) == 0) ? 32'h3100_0000 : 32'h3000_0000) | (32'(p) << 16);
            a = a | (($urandom_range(0, 5) == 0) ? 32'($urandom_range(0, 65535))
                                                 : 32'($urandom_range(0, 255)) << 2);
            mode = $urandom_range(0, 9);
            mode = (mode <= 6) ? 0 : ((mode == 7) ? 1 : 2);
            do_txn(a, 1'($urandom), 4'($urandom), $urandom, mode, $urandom_range(0, 5),
                   $urandom, ra, re, rdd, ns);
            $display("txn rand%0d adr=%h mode=%0d ack=%0d err=%0d dat=%h stb=%0d",
                     t, a, mode, ra, re, rdd, ns);
        end

        // Saturate the fault counter.
        for (int t = 0; t < 300; t++) begin
            do_txn(32'h4000_0000 | 32'($urandom_range(0, 4095)), 1'b0, 4'hf, 32'h0, 0, 0,
                   32'h0, ra, re, rdd, ns);
        end
        $display("txn saturate fault_cnt=%0d", fault_cnt_o);
        chk("sat_fault_cnt", fault_cnt_o, 8'd255);

        // Reset while a read to port 3 is active.
        cyc = 1'b1; stb = 1'b1; we = 1'b0; sel = 4'hf; adr = 32'h3003_0020; wdat = 32'h0;
        noise(-1); set_idle();
        step(); noise(3);
        e_port = 3; e_adr = 32'h3003_0020; e_wdat = 32'h0; e_sel = 4'hf; e_we = 1'b0;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1; cyc = 1'b0; stb = 1'b0; noise(-1); set_idle();
        m_fault_cnt = 0; m_fault_adr = 32'h0;
        $display("txn midreset stb=%h ack=%0d fault_cnt=%0d", wbs_dfp_stb_o, wbs_ufp_ack_o, fault_cnt_o);
        chk("rst_mid_stb", wbs_dfp_stb_o, '0);
        chk("rst_mid_ack", wbs_ufp_ack_o, 1'b0);
        chk("rst_mid_fault_cnt", fault_cnt_o, 8'd0);
        chk("rst_mid_fault_adr", fault_adr_o, 32'h0);
        step(); step();

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
